// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: dcache normally wins, but icache is granted after
// STARVE_MAX back-to-back dcache completions while it waits.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [1:0]  ramstate,
  input  logic [31:0] ramload,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ramerr
);

  typedef enum logic [1:0] {IDLE, DGNT, IGNT} owner_t;

  localparam logic [1:0] RS_ACCESS  = 2'd2;
  localparam logic [1:0] RS_ERROR   = 2'd3;
  localparam logic [2:0] STREAK_MAX = 3'(STARVE_MAX);

  owner_t      owner_q, owner_d, pick;
  logic [2:0]  streak_q, streak_d;
  logic        ramerr_q, ramerr_d;
  logic        d_req, owner_req, access, complete;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      owner_q  <= IDLE;
      streak_q <= 3'd0;
      ramerr_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      streak_q <= streak_d;
      ramerr_q <= ramerr_d;
    end
  end

  always_comb begin
    d_req     = dREN | dWEN;
    access    = (ramstate == RS_ACCESS);
    owner_req = 1'b0;
    case (owner_q)
      DGNT:    owner_req = d_req;
      IGNT:    owner_req = iREN;
      default: owner_req = 1'b0;
    endcase
    // An access whose requester has already let go is an abort, not a completion.
    complete = (owner_q != IDLE) && access && owner_req;

    streak_d = streak_q;
    if (complete && owner_q == IGNT)
      streak_d = 3'd0;
    else if (complete && owner_q == DGNT && iREN && streak_q < STREAK_MAX)
      streak_d = streak_q + 3'd1;

    // Arbitrate on the post-completion streak so the limit takes effect immediately.
    if (d_req && !(iREN && streak_d >= STREAK_MAX))
      pick = DGNT;
    else if (iREN)
      pick = IGNT;
    else
      pick = IDLE;

    owner_d = owner_q;
    if (owner_q == IDLE || access || !owner_req)
      owner_d = pick;

    ramerr_d = ramerr_q | ((owner_q != IDLE) && (ramstate == RS_ERROR));
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    iwait    = iREN;
    dwait    = d_req;
    case (owner_q)
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~access;
      end
      IGNT: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        iwait   = ~access;
      end
      default: ;
    endcase
  end

  assign iload  = ramload;
  assign dload  = ramload;
  assign ramerr = ramerr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed multi-cycle sequences, and a
// randomized run against a behavioural model of the arbitration rules.
module tb_mem_arbiter;

  localparam int STARVE = 4;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, ramerr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_chk = 0;
  int n_fail = 0;

  mem_arbiter #(.STARVE_MAX(STARVE)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ramstate(ramstate), .ramload(ramload),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramerr(ramerr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic dr, input logic dw, input logic [1:0] rs,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                       input logic [31:0] rl);
    @(negedge CLK);
    iREN = ir; dREN = dr; dWEN = dw; ramstate = rs;
    iaddr = ia; daddr = da; dstore = ds; ramload = rl;
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        ir, dr, dw;
    logic [1:0]  rs;
    logic [31:0] ia, da, ds, rl;
    logic        e_iw, e_dw, e_ren, e_wen;
    logic [31:0] e_addr, e_store;
  } vec_t;

  function automatic vec_t mk(logic ir, logic dr, logic dw, logic [1:0] rs,
                              logic [31:0] ia, logic [31:0] da, logic [31:0] ds, logic [31:0] rl,
                              logic iw, logic dwt, logic ren, logic wen,
                              logic [31:0] addr, logic [31:0] st);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.rs = rs; v.ia = ia; v.da = da; v.ds = ds; v.rl = rl;
    v.e_iw = iw; v.e_dw = dwt; v.e_ren = ren; v.e_wen = wen; v.e_addr = addr; v.e_store = st;
    return v;
  endfunction

  vec_t tbl[17];

  // ---------------- behavioural reference ----------------
  int m_own;     // 0 nobody, 1 dcache, 2 icache
  int m_streak;
  bit m_err;

  function automatic int m_pick(int s);
    if ((dREN || dWEN) && !(iREN && s >= STARVE)) return 1;
    if (iREN) return 2;
    return 0;
  endfunction

  function automatic logic [68:0] m_out();
    logic iw, dwt, ren, wen;
    logic [31:0] a, st;
    iw = iREN; dwt = dREN | dWEN; ren = 0; wen = 0; a = 0; st = 0;
    if (m_own == 1) begin
      a = daddr; st = dstore; wen = dWEN; ren = dREN && !dWEN; dwt = (ramstate != ACC);
    end else if (m_own == 2) begin
      a = iaddr; ren = 1; iw = (ramstate != ACC);
    end
    return {iw, dwt, ren, wen, m_err, a, st};
  endfunction

  task automatic m_adv();
    bit oreq, acc;
    oreq = (m_own == 1) ? (dREN || dWEN) : (m_own == 2) ? iREN : 1'b0;
    acc  = (ramstate == ACC);
    if (m_own != 0 && ramstate == ERR) m_err = 1;
    if (m_own != 0 && acc && oreq) begin
      if (m_own == 2) m_streak = 0;
      else if (iREN && m_streak < STARVE) m_streak++;
    end
    if (m_own == 0 || acc || !oreq) m_own = m_pick(m_streak);
  endtask

  // Each slot is one BUSY cycle then one ACCESS cycle with both caches requesting.
  task automatic run_grants(input string tag, input string exp);
    logic [31:0] e;
    for (int k = 0; k < exp.len(); k++) begin
      drive(1, 1, 0, BUSY, 32'h10, 32'hD0, 32'h0, 32'h0);
      drive(1, 1, 0, ACC,  32'h10, 32'hD0, 32'h0, 32'h0);
      e = (exp.getc(k) == "D") ? 32'hD0 : 32'h10;
      chk($sformatf("%s_grant%0d", tag, k), ramaddr, e);
    end
  endtask

  initial begin
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0; ramstate = FREE;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;

    tbl[0]  = mk(0,0,0,FREE,32'h40,0,0,0,                         0,0,0,0,0,0);
    tbl[1]  = mk(1,0,0,FREE,32'h40,0,0,0,                         1,0,0,0,0,0);
    tbl[2]  = mk(1,0,0,BUSY,32'h40,0,0,0,                         1,0,1,0,32'h40,0);
    tbl[3]  = mk(1,0,0,BUSY,32'h40,0,0,0,                         1,0,1,0,32'h40,0);
    tbl[4]  = mk(1,0,0,ACC, 32'h40,0,0,32'h12345678,              0,0,1,0,32'h40,0);
    tbl[5]  = mk(0,0,0,FREE,32'h40,0,0,0,                         1,0,1,0,32'h40,0);
    tbl[6]  = mk(0,0,0,FREE,32'h40,0,0,0,                         0,0,0,0,0,0);
    tbl[7]  = mk(1,1,0,FREE,32'h40,32'h200,32'h55,0,              1,1,0,0,0,0);
    tbl[8]  = mk(1,1,0,BUSY,32'h40,32'h200,32'h55,0,              1,1,1,0,32'h200,32'h55);
    tbl[9]  = mk(1,1,0,ACC, 32'h40,32'h200,32'h55,32'hA5A5A5A5,   1,0,1,0,32'h200,32'h55);
    tbl[10] = mk(1,0,0,FREE,32'h40,32'h200,32'h55,0,              1,1,0,0,32'h200,32'h55);
    tbl[11] = mk(1,0,0,ACC, 32'h40,32'h200,32'h55,32'h77,         0,0,1,0,32'h40,0);
    tbl[12] = mk(0,1,1,FREE,32'h40,32'h3100,32'hDEADBEEF,0,       1,1,1,0,32'h40,0);
    tbl[13] = mk(0,1,1,BUSY,32'h40,32'h3100,32'hDEADBEEF,0,       0,1,0,1,32'h3100,32'hDEADBEEF);
    tbl[14] = mk(0,1,1,ACC, 32'h40,32'h3100,32'hDEADBEEF,32'h9,   0,0,0,1,32'h3100,32'hDEADBEEF);
    tbl[15] = mk(0,0,0,FREE,32'h40,0,0,0,                         0,1,0,0,0,0);
    tbl[16] = mk(0,0,0,FREE,0,0,0,0,                              0,0,0,0,0,0);

    // reset state
    #2;
    chk("reset_outputs", {ramREN, ramWEN, ramerr, ramaddr, ramstore}, 67'd0);
    @(negedge CLK); nRST = 1;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].ir, tbl[i].dr, tbl[i].dw, tbl[i].rs, tbl[i].ia, tbl[i].da, tbl[i].ds, tbl[i].rl);
      chk($sformatf("vec%0d", i), {iwait, dwait, ramREN, ramWEN, ramaddr, ramstore},
          {tbl[i].e_iw, tbl[i].e_dw, tbl[i].e_ren, tbl[i].e_wen, tbl[i].e_addr, tbl[i].e_store});
      chk($sformatf("vec%0d_load", i), {iload, dload}, {tbl[i].rl, tbl[i].rl});
    end

    // starvation limit: four dcache completions, then one icache, then dcache again
    drive(1, 1, 0, FREE, 32'h10, 32'hD0, 0, 0);
    run_grants("starve", "DDDDIDDDDI");
    drive(0, 0, 0, FREE, 0, 0, 0, 0);
    drive(0, 0, 0, FREE, 0, 0, 0, 0);
    chk("starve_idle", {ramREN, ramaddr}, 33'd0);

    // sticky error under a dcache grant
    drive(0, 1, 0, FREE, 0, 32'h80, 0, 0);
    drive(0, 1, 0, BUSY, 0, 32'h80, 0, 0);
    drive(0, 1, 0, ERR,  0, 32'h80, 0, 0);
    chk("err_cycle", {dwait, ramerr, ramaddr}, {1'b1, 1'b0, 32'h80});
    drive(0, 1, 0, BUSY, 0, 32'h80, 0, 0);
    chk("err_hold", {dwait, ramerr, ramREN, ramaddr}, {1'b1, 1'b1, 1'b1, 32'h80});
    drive(0, 1, 0, ACC,  0, 32'h80, 0, 0);
    chk("err_access", {dwait, ramerr}, {1'b0, 1'b1});
    for (int i = 0; i < 3; i++) drive(0, 0, 0, FREE, 0, 0, 0, 0);
    chk("err_sticky", ramerr, 1'b1);
    nRST = 0; #1;
    chk("err_cleared_by_reset", ramerr, 1'b0);
    @(negedge CLK); nRST = 1;

    // reset in the middle of an icache access, with a partly built streak
    drive(1, 1, 0, FREE, 32'h10, 32'hD0, 0, 0);
    run_grants("prerst", "DDD");
    drive(1, 0, 0, FREE, 32'h10, 32'hD0, 0, 0);
    drive(1, 0, 0, BUSY, 32'h10, 32'hD0, 0, 0);
    chk("rst_pre_igrant", {ramREN, ramaddr}, {1'b1, 32'h10});
    #1 nRST = 0; #1;
    chk("rst_strobe_drop", {ramREN, ramWEN, ramaddr, ramstore}, 66'd0);
    @(negedge CLK);
    nRST = 1; iREN = 1; dREN = 1; dWEN = 0; ramstate = FREE; #1;
    chk("rst_release_idle", {iwait, dwait, ramREN, ramaddr}, {1'b1, 1'b1, 1'b0, 32'h0});
    run_grants("postrst", "DDDDI");
    drive(0, 0, 0, FREE, 0, 0, 0, 0);
    drive(0, 0, 0, FREE, 0, 0, 0, 0);

    // randomized run against the reference model
    m_own = 0; m_streak = 0; m_err = 0;
    for (int c = 0; c < 4000; c++) begin
      int r;
      @(negedge CLK);
      if ($urandom_range(0, 3) == 0) iREN = 1'($urandom);
      if ($urandom_range(0, 3) == 0) dREN = 1'($urandom);
      if ($urandom_range(0, 3) == 0) dWEN = 1'($urandom);
      r = $urandom_range(0, 63);
      ramstate = (r < 20) ? FREE : (r < 40) ? BUSY : (r < 62) ? ACC : ERR;
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      nRST = (c % 300 == 299) ? 1'b0 : 1'b1;
      #1;
      if (!nRST) begin m_own = 0; m_streak = 0; m_err = 0; end
      chk($sformatf("rand%0d", c),
          {iwait, dwait, ramREN, ramWEN, ramerr, ramaddr, ramstore}, m_out());
      if (iload !== ramload || dload !== ramload)
        chk($sformatf("rand%0d_load", c), {iload, dload}, {ramload, ramload});
      if (nRST) m_adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port: CLK  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port: nRST  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: iREN  input  1  icache read request.
REQ-004 SHALL have port: iaddr  input  32  icache word address.
REQ-005 SHALL have port: dREN, dWEN  input  1 each  dcache read / write request.
REQ-006 SHALL have port: daddr, dstore  input  32 each  dcache address / write data.
REQ-007 SHALL have port: ramstate  input  2  RAM status, encoded FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-008 SHALL have port: ramload  input  32  RAM read data.
REQ-009 SHALL have port: iwait, dwait  output  1 each  requester stall.
REQ-010 SHALL have port: iload, dload  output  32 each  read data returned to requester.
REQ-011 SHALL have port: ramREN, ramWEN  output  1 each  RAM strobes.
REQ-012 SHALL have port: ramaddr, ramstore  output  32 each  RAM address / write data.
REQ-013 SHALL have port: ramerr  output  1  sticky error flag.
REQ-014 SHALL have parameter: STARVE_MAX, default 4, max consecutive dcache completions while iREN is pending.

Function
REQ-015 SHALL hold a registered owner state: IDLE, DGNT, IGNT.
REQ-016 SHALL define pick(): DGNT if (dREN|dWEN) and not (iREN and streak>=STARVE_MAX); else IGNT if iREN; else IDLE.
REQ-017 SHALL load owner <= pick() every cycle when state is IDLE, or when the current owner completes (ramstate==ACCESS), or when the current owner drops its request.
REQ-018 SHALL otherwise keep owner unchanged (BUSY, FREE, ERROR hold grant).
REQ-019 SHALL, in IDLE, drive ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1 when requesting (0 when not).
REQ-020 SHALL, in DGNT, drive ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both).
REQ-021 SHALL, in IGNT, drive ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-022 SHALL drive owner's wait = (ramstate!=ACCESS); non-owner's wait = 1 if requesting.
REQ-023 SHALL drive iload=dload=ramload combinationally at all times; data is valid only in the owner's ACCESS cycle.
REQ-024 SHALL implement streak as a 3-bit counter saturating at STARVE_MAX.
REQ-025 SHALL increment streak on each dcache completion while iREN=1.
REQ-026 SHALL clear streak on each icache completion.
REQ-027 SHALL leave streak unchanged on a dcache completion while iREN=0.
REQ-028 SHALL grant one arbitration cycle of latency from IDLE; back-to-back grants after a completion incur no idle cycle.
REQ-029 SHALL set ramerr on any cycle with ramstate==ERROR under a grant; ramerr clears only on reset; grant and wait are held during ERROR.
REQ-030 SHALL treat a request dropped mid-access as aborted: no completion counted, no streak change, re-arbitrate next edge.
REQ-031 SHALL, on simultaneous first requests from IDLE, grant dcache.

Reset
REQ-032 SHALL, while nRST=0, set owner=IDLE, streak=0, ramerr=0 asynchronously.
REQ-033 SHALL, during reset, drive ramREN=ramWEN=0 and ramaddr=ramstore=0.
REQ-034 SHALL, on reset mid-access, drop the RAM strobes immediately and not resume the access after release.
REQ-035 SHALL, on first edge after release, arbitrate from IDLE.

Verification
REQ-036 SHALL test: iREN=1, iaddr=0x40, ramstate=ACCESS after 2 BUSY cycles -> IGNT next cycle; iwait low only in ACCESS cycle; iload=ramload.
REQ-037 SHALL test: iREN and dREN raised together from IDLE -> DGNT, ramaddr=daddr, iwait=1 until dcache completes.
REQ-038 SHALL test: dREN and iREN held, 5 dcache completions attempted -> 4 dcache completions, then IGNT for 1 completion, streak=0, then DGNT.
REQ-039 SHALL test: dWEN=dREN=1, daddr=0x3100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
REQ-040 SHALL test: ramstate=ERROR for 1 cycle during DGNT -> ramerr=1 until nRST; dwait held high.
REQ-041 SHALL test: nRST asserted during BUSY under IGNT -> ramREN=0 immediately; owner=IDLE, streak=0 after release.
